// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the two-cache / one-memory arbiter: message layout,
// type encoding and arbiter FSM states.
package cache_mem_arbiter_pkg;

    localparam int REQ_W         = 65;
    localparam int RESP_W        = 33;
    localparam int REQ_TYPE_BIT  = 64;
    localparam int ADDR_MSB      = 63;
    localparam int ADDR_LSB      = 32;
    localparam int DATA_MSB      = 31;
    localparam int DATA_LSB      = 0;
    localparam int RESP_TYPE_BIT = 32;

    typedef enum logic {
        MSG_READ  = 1'b0,
        MSG_WRITE = 1'b1
    } msg_type_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    function automatic logic [REQ_W-1:0] pack_req(input msg_type_e t,
                                                 input logic [31:0] addr,
                                                 input logic [31:0] data);
        return {t, addr, data};
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Request/response valid-ready channel pair between a requester (master)
// and a responder (slave).
interface cache_mem_arbiter_if;
    import cache_mem_arbiter_pkg::*;

    logic              req_val;
    logic              req_rdy;
    logic [REQ_W-1:0]  req_msg;
    logic              resp_val;
    logic              resp_rdy;
    logic [RESP_W-1:0] resp_msg;

    modport master (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );
endinterface

// File: rtl/cache_mem_arbiter_idfifo.sv
// Small FIFO of 1-bit requester ids used to route in-order memory responses.
// A push into a full FIFO is refused even when a pop happens in the same cycle.
module cache_mem_arbiter_idfifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DEPTH-1:0] ids_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Status flags and qualified push/pop strobes.
    always_comb begin
        full      = (count_r == CNT_FULL);
        empty     = (count_r == {CW{1'b0}});
        dout      = ids_r[rd_ptr_r];
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ids_r    <= {DEPTH{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                ids_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-cache to one-memory arbiter: line-burst locked grants with alternating
// priority, combinational request/response paths, responses routed by id FIFO.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    cache_mem_arbiter_if.slave         c0,
    cache_mem_arbiter_if.slave         c1,
    cache_mem_arbiter_if.master        mem
);
    localparam int WCNT_W = $clog2(LINE_WORDS);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(LINE_WORDS - 1);

    arb_state_e        state_r, state_s;
    logic              owner_r, owner_s;
    logic              prio_r, prio_s;
    logic [WCNT_W-1:0] wcnt_r, wcnt_s;

    logic fifo_full_s, fifo_empty_s, fifo_head_s;
    logic sel_s, sel_val_s, issue_rdy_s, req_fire_s;
    logic dest_rdy_s, resp_fire_s;

    // Request mux: in a burst only the owner passes; outputs forced low in reset.
    always_comb begin
        if (state_r == ST_BURST) begin
            sel_s = owner_r;
        end else if (c0.req_val && c1.req_val) begin
            sel_s = prio_r;
        end else begin
            sel_s = c1.req_val;
        end
        sel_val_s   = sel_s ? c1.req_val : c0.req_val;
        issue_rdy_s = reset & mem.req_rdy & ~fifo_full_s;
        mem.req_msg = sel_s ? c1.req_msg : c0.req_msg;
        mem.req_val = reset & sel_val_s & ~fifo_full_s;
        c0.req_rdy  = issue_rdy_s & ~sel_s;
        c1.req_rdy  = issue_rdy_s & sel_s;
        req_fire_s  = mem.req_val & mem.req_rdy;
    end

    // Response routing by FIFO head; unsolicited responses are neither forwarded nor taken.
    always_comb begin
        dest_rdy_s   = fifo_head_s ? c1.resp_rdy : c0.resp_rdy;
        mem.resp_rdy = reset & ~fifo_empty_s & dest_rdy_s;
        c0.resp_val  = reset & mem.resp_val & ~fifo_empty_s & ~fifo_head_s;
        c1.resp_val  = reset & mem.resp_val & ~fifo_empty_s & fifo_head_s;
        c0.resp_msg  = mem.resp_msg;
        c1.resp_msg  = mem.resp_msg;
        resp_fire_s  = mem.resp_val & mem.resp_rdy;
    end

    // Grant FSM next state: lock on first word, release and flip priority on the last.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        prio_s  = prio_r;
        wcnt_s  = wcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_fire_s) begin
                    owner_s = sel_s;
                    wcnt_s  = WCNT_ONE;
                    state_s = ST_BURST;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (req_fire_s && (wcnt_r == WCNT_LAST)) begin
                    wcnt_s  = {WCNT_W{1'b0}};
                    prio_s  = ~owner_r;
                    state_s = ST_IDLE;
                end else if (req_fire_s) begin
                    wcnt_s = wcnt_r + WCNT_ONE;
                end else begin
                    wcnt_s = wcnt_r;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Grant FSM state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            owner_r <= 1'b0;
            prio_r  <= 1'b0;
            wcnt_r  <= {WCNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            prio_r  <= prio_s;
            wcnt_r  <= wcnt_s;
        end
    end

    cache_mem_arbiter_idfifo #(.DEPTH(MAX_OUTST)) u_idfifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire_s),
        .pop   (resp_fire_s),
        .din   (sel_s),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: cache/memory models on the three
// channels, expected memory order and expected responses checked in queues.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    typedef struct packed { logic id; logic [REQ_W-1:0] msg; } exp_req_t;
    typedef struct packed { logic id; logic [RESP_W-1:0] msg; } exp_resp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cache_mem_arbiter_if c0_if();
    cache_mem_arbiter_if c1_if();
    cache_mem_arbiter_if mem_if();

    cache_mem_arbiter #(.LINE_WORDS(4), .MAX_OUTST(4)) dut (
        .clk(clk), .reset(reset), .c0(c0_if), .c1(c1_if), .mem(mem_if)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [REQ_W-1:0] c0_q[$], c1_q[$], mem_q[$];
    exp_req_t  exp_req[$];
    exp_resp_t exp_resp[$];

    int mem_budget, c0_gap_at, c0_gap_left, c0_sent;
    int c0_resp_cnt, c1_resp_cnt, mfire_cnt;
    bit mem_force, mem_rdy_en, c0_rrdy, c1_rrdy;
    bit f_c0req, f_c1req, f_mreq, f_mresp, gap_s;
    logic [REQ_W-1:0] mreq_msg_s;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [REQ_W-1:0] m);
        return m[REQ_TYPE_BIT] ? m[DATA_MSB:DATA_LSB] : (m[ADDR_MSB:ADDR_LSB] ^ 32'h5A5A_0000);
    endfunction

    task automatic drive();
        gap_s = (c0_gap_left > 0) && (c0_sent == c0_gap_at);
        c0_if.req_val  = (c0_q.size() > 0) && !gap_s;
        c0_if.req_msg  = (c0_q.size() > 0) ? c0_q[0] : {REQ_W{1'b0}};
        c1_if.req_val  = (c1_q.size() > 0);
        c1_if.req_msg  = (c1_q.size() > 0) ? c1_q[0] : {REQ_W{1'b0}};
        c0_if.resp_rdy = c0_rrdy;
        c1_if.resp_rdy = c1_rrdy;
        mem_if.req_rdy = mem_rdy_en;
        mem_if.resp_val = mem_force || ((mem_q.size() > 0) && (mem_budget > 0));
        mem_if.resp_msg = (mem_q.size() > 0) ? {mem_q[0][REQ_TYPE_BIT], mem_data(mem_q[0])}
                                             : {1'b0, 32'hDEAD_BEEF};
    endtask

    task automatic check_resp(input logic id, input logic [RESP_W-1:0] msg);
        exp_resp_t r;
        check_val("resp_expected", exp_resp.size() > 0, 1'b1);
        if (exp_resp.size() > 0) begin
            r = exp_resp.pop_front();
            check_val("resp_dest", id, r.id);
            check_val("resp_msg", msg, r.msg);
        end
    endtask

    task automatic sample_edge();
        exp_req_t  e;
        exp_resp_t r;
        drive();
        @(negedge clk); #1;
        f_c0req    = c0_if.req_val && c0_if.req_rdy;
        f_c1req    = c1_if.req_val && c1_if.req_rdy;
        f_mreq     = mem_if.req_val && mem_if.req_rdy;
        f_mresp    = mem_if.resp_val && mem_if.resp_rdy;
        mreq_msg_s = mem_if.req_msg;
        if (gap_s) begin
            check_val("lock_c1_rdy", c1_if.req_rdy, 1'b0);
            check_val("lock_mem_val", mem_if.req_val, 1'b0);
        end
        if (f_mreq) begin
            mfire_cnt++;
            check_val("req_expected", exp_req.size() > 0, 1'b1);
            if (exp_req.size() > 0) begin
                e = exp_req.pop_front();
                check_val("req_msg", mem_if.req_msg, e.msg);
                r.id  = e.id;
                r.msg = {e.msg[REQ_TYPE_BIT], mem_data(e.msg)};
                exp_resp.push_back(r);
            end
        end
        if (c0_if.resp_val && c0_if.resp_rdy) begin
            c0_resp_cnt++;
            check_resp(1'b0, c0_if.resp_msg);
        end
        if (c1_if.resp_val && c1_if.resp_rdy) begin
            c1_resp_cnt++;
            check_resp(1'b1, c1_if.resp_msg);
        end
    endtask

    task automatic advance();
        @(posedge clk); #1;
        if (f_c0req) begin
            void'(c0_q.pop_front());
            c0_sent++;
        end
        if (gap_s) c0_gap_left--;
        if (f_c1req) void'(c1_q.pop_front());
        if (f_mresp && (mem_q.size() > 0)) begin
            void'(mem_q.pop_front());
            mem_budget--;
        end
        if (f_mreq) mem_q.push_back(mreq_msg_s);
        {f_c0req, f_c1req, f_mreq, f_mresp} = 4'b0000;
    endtask

    task automatic cycle();
        sample_edge();
        advance();
    endtask

    task automatic clear_models();
        c0_q.delete(); c1_q.delete(); mem_q.delete();
        exp_req.delete(); exp_resp.delete();
        mem_budget = 1000; mem_force = 1'b0; mem_rdy_en = 1'b1;
        c0_rrdy = 1'b1; c1_rrdy = 1'b1;
        c0_gap_at = -1; c0_gap_left = 0; c0_sent = 0;
        c0_resp_cnt = 0; c1_resp_cnt = 0; mfire_cnt = 0;
        {f_c0req, f_c1req, f_mreq, f_mresp} = 4'b0000;
    endtask

    // Ends one microsecond-free step after a posedge, ready to drive the next cycle.
    task automatic do_reset();
        reset = 1'b0;
        clear_models();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load(input logic id, input int n, input logic [31:0] base, input msg_type_e t);
        for (int i = 0; i < n; i++) begin
            if (id) c1_q.push_back(pack_req(t, base + 32'(4 * i), 32'hC100_0000 + 32'(i)));
            else    c0_q.push_back(pack_req(t, base + 32'(4 * i), 32'hC000_0000 + 32'(i)));
        end
    endtask

    task automatic expect_words(input logic id, input int lo, input int n);
        exp_req_t e;
        for (int i = 0; i < n; i++) begin
            e.id  = id;
            e.msg = id ? c1_q[lo + i] : c0_q[lo + i];
            exp_req.push_back(e);
        end
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while ((c0_q.size() + c1_q.size() + exp_req.size() + exp_resp.size() + mem_q.size() > 0)
               && (n < max_cycles)) begin
            cycle();
            n++;
        end
        check_val("drain", c0_q.size() + c1_q.size() + exp_req.size() + exp_resp.size(), 0);
    endtask

    task automatic check_all_quiet(input string tag);
        check_val({tag, "_c0_req_rdy"}, c0_if.req_rdy, 1'b0);
        check_val({tag, "_c1_req_rdy"}, c1_if.req_rdy, 1'b0);
        check_val({tag, "_mem_req_val"}, mem_if.req_val, 1'b0);
        check_val({tag, "_mem_resp_rdy"}, mem_if.resp_rdy, 1'b0);
        check_val({tag, "_c0_resp_val"}, c0_if.resp_val, 1'b0);
        check_val({tag, "_c1_resp_val"}, c1_if.resp_val, 1'b0);
    endtask

    initial begin
        // Reset state with live inputs: everything must stay quiet.
        clear_models();
        load(1'b0, 1, 32'h0000_0100, MSG_READ);
        mem_force = 1'b1;
        drive();
        #3;
        check_all_quiet("rst");

        // Single refill from c0.
        do_reset();
        load(1'b0, 4, 32'h0000_1000, MSG_READ);
        expect_words(1'b0, 0, 4);
        run_until_idle(100);
        check_val("refill_fires", mfire_cnt, 4);
        check_val("refill_c0_resp", c0_resp_cnt, 4);
        check_val("refill_c1_resp", c1_resp_cnt, 0);

        // Contention, burst lock across a 3-cycle c0 gap, then alternation.
        do_reset();
        load(1'b0, 8, 32'h0000_2000, MSG_READ);
        load(1'b1, 8, 32'h0000_3000, MSG_WRITE);
        expect_words(1'b0, 0, 4);
        expect_words(1'b1, 0, 4);
        expect_words(1'b0, 4, 4);
        expect_words(1'b1, 4, 4);
        c0_gap_at = 2; c0_gap_left = 3;
        run_until_idle(200);
        check_val("fair_gap_used", c0_gap_left, 0);
        check_val("fair_c0_resp", c0_resp_cnt, 8);
        check_val("fair_c1_resp", c1_resp_cnt, 8);

        // Outstanding limit with memory withholding responses.
        do_reset();
        mem_budget = 0;
        load(1'b0, 4, 32'h0000_4000, MSG_READ);
        load(1'b1, 4, 32'h0000_5000, MSG_READ);
        expect_words(1'b0, 0, 4);
        expect_words(1'b1, 0, 4);
        repeat (4) cycle();
        sample_edge();
        check_val("full_mem_val", mem_if.req_val, 1'b0);
        check_val("full_c1_rdy", c1_if.req_rdy, 1'b0);
        advance();
        mem_budget = 1;
        sample_edge();
        check_val("pop_cycle_mem_val", mem_if.req_val, 1'b0);
        check_val("pop_cycle_resp_rdy", mem_if.resp_rdy, 1'b1);
        advance();
        sample_edge();
        check_val("one_issue_val", mem_if.req_val, 1'b1);
        check_val("one_issue_c1_rdy", c1_if.req_rdy, 1'b1);
        advance();
        sample_edge();
        check_val("refull_val", mem_if.req_val, 1'b0);
        advance();
        mem_budget = 1000;
        run_until_idle(200);

        // Response backpressure from c1.
        do_reset();
        mem_budget = 0;
        load(1'b1, 4, 32'h0000_6000, MSG_WRITE);
        expect_words(1'b1, 0, 4);
        repeat (4) cycle();
        c1_rrdy = 1'b0;
        mem_budget = 1000;
        for (int i = 0; i < 3; i++) begin
            sample_edge();
            check_val("bp_c1_val", c1_if.resp_val, 1'b1);
            check_val("bp_mem_rdy", mem_if.resp_rdy, 1'b0);
            check_val("bp_c0_val", c0_if.resp_val, 1'b0);
            advance();
        end
        c1_rrdy = 1'b1;
        sample_edge();
        check_val("bp_release_rdy", mem_if.resp_rdy, 1'b1);
        advance();
        run_until_idle(100);
        check_val("bp_c1_resp", c1_resp_cnt, 4);

        // Reset in the middle of a c1 burst.
        do_reset();
        load(1'b1, 4, 32'h0000_7000, MSG_READ);
        expect_words(1'b1, 0, 4);
        repeat (2) cycle();
        load(1'b0, 1, 32'h0000_7800, MSG_READ);
        mem_force = 1'b1;
        drive();
        #2;
        reset = 1'b0;
        #1;
        check_all_quiet("midrst");
        clear_models();
        drive();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        load(1'b0, 4, 32'h0000_8000, MSG_READ);
        load(1'b1, 4, 32'h0000_9000, MSG_READ);
        expect_words(1'b0, 0, 4);
        expect_words(1'b1, 0, 4);
        mem_force = 1'b1;
        sample_edge();
        check_val("post_rst_c0_wins", c0_if.req_rdy, 1'b1);
        check_val("unsol_mem_rdy", mem_if.resp_rdy, 1'b0);
        check_val("unsol_c0_val", c0_if.resp_val, 1'b0);
        check_val("unsol_c1_val", c1_if.resp_val, 1'b0);
        advance();
        mem_force = 1'b0;
        run_until_idle(200);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
